banked_psr: RTL

BANKED_PSR -- requirements
Module: banked_psr

---
 rtl/banked_psr_if.sv | 31 +++
 rtl/banked_psr.sv | 138 +++++++++++++
 2 files changed

// File: rtl/banked_psr_if.sv
// banked_psr_if: control and data bundle for the banked PSR.
// The master drives the write, save and restore controls. The slave returns q, sq, valid and err.
interface banked_psr_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORD  = 4,
  parameter int unsigned BANKS = 4
);
  localparam int unsigned FULLW = WIDTH * WORD;
  localparam int unsigned SELW  = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic             we;
  logic [WORD-1:0]  be;
  logic [FULLW-1:0] d;
  logic             save;
  logic             restore;
  logic [SELW-1:0]  sel;
  logic [FULLW-1:0] q;
  logic [FULLW-1:0] sq;
  logic [BANKS-1:0] valid;
  logic             err;

  modport master (
    output we, be, d, save, restore, sel,
    input  q, sq, valid, err
  );

  modport slave (
    input  we, be, d, save, restore, sel,
    output q, sq, valid, err
  );
endinterface

// File: rtl/banked_psr.sv
// banked_psr: a byte-lane writable status register with BANKS saved copies.
// Storage is big-endian: packed index 0 holds lane WORD-1, so the flat vector lines up with the port bits.
// Define BANKED_PSR_SWAP_EN to make a same-cycle save+restore swap the register with the bank.
// Without BANKED_PSR_SWAP_EN, the restore takes priority and the save is ignored.
module banked_psr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORD  = 4,
  parameter int unsigned BANKS = 4
) (
  input logic        clk,
  input logic        rst_n,
  banked_psr_if.slave bus
);
  localparam int unsigned FULLW = WIDTH * WORD;
  localparam int unsigned SELW  = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef logic [0:WORD-1][WIDTH-1:0] word_t;

  word_t            cur_r;
  word_t            cur_nxt;
  word_t            bank_r [BANKS];
  logic [BANKS-1:0] valid_r;
  logic [FULLW-1:0] q_r;
  logic [FULLW-1:0] sq_r;
  logic             err_r;

  logic sel_ok;
  logic sel_valid;
  logic do_write;
  logic do_save;
  logic do_load;
  logic set_valid;
  logic clr_valid;
  logic err_nxt;

  // Decode save/restore/write priority and legality for this cycle
  always_comb begin
    sel_ok    = (32'(bus.sel) < BANKS);
    sel_valid = sel_ok && valid_r[bus.sel];
    do_write  = 1'b0;
    do_save   = 1'b0;
    do_load   = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    err_nxt   = 1'b0;
    if (bus.restore) begin
      if (!sel_ok) begin
        err_nxt = 1'b1;
      end else if (sel_valid) begin
        do_load = 1'b1;
`ifdef BANKED_PSR_SWAP_EN
        if (bus.save) begin
          do_save = 1'b1;
        end else begin
          clr_valid = 1'b1;
        end
`else
        clr_valid = 1'b1;
`endif
      end else begin
`ifdef BANKED_PSR_SWAP_EN
        // An empty bank degrades to a plain save, including the same-cycle write
        if (bus.save) begin
          do_save   = 1'b1;
          set_valid = 1'b1;
          do_write  = bus.we;
        end else begin
          err_nxt = 1'b1;
        end
`else
        err_nxt = 1'b1;
`endif
      end
    end else if (bus.save) begin
      if (sel_ok) begin
        do_save   = 1'b1;
        set_valid = 1'b1;
        do_write  = bus.we;
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      do_write = bus.we;
    end
  end

  // Next value of the current register: a restore load, or a byte-lane merge of d
  always_comb begin
    cur_nxt = cur_r;
    if (do_load) begin
      cur_nxt = bank_r[bus.sel];
    end else if (do_write) begin
      for (int i = 0; i < int'(WORD); i++) begin
        if (bus.be[i]) begin
          cur_nxt[int'(WORD) - 1 - i] = bus.d[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Current register, valid flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_r   <= '0;
      valid_r <= '0;
      q_r     <= '0;
      sq_r    <= '0;
      err_r   <= 1'b0;
    end else begin
      cur_r <= cur_nxt;
      if (set_valid) begin
        valid_r[bus.sel] <= 1'b1;
      end else if (clr_valid) begin
        valid_r[bus.sel] <= 1'b0;
      end
      q_r   <= cur_r;
      sq_r  <= sel_ok ? bank_r[bus.sel] : '0;
      err_r <= err_nxt;
    end
  end

  // Saved-copy banks capture the pre-edge current value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < int'(BANKS); b++) begin
        bank_r[b] <= '0;
      end
    end else if (do_save) begin
      bank_r[bus.sel] <= cur_r;
    end
  end

  assign bus.q     = q_r;
  assign bus.sq    = sq_r;
  assign bus.valid = valid_r;
  assign bus.err   = err_r;

endmodule
